// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory req/ack port, redirect input,
// and the valid/ready head port toward decode. The master side is the fetch stage.
interface fetch_queue_if #(
   parameter int unsigned PC_WIDTH = 32,
   parameter int unsigned IWIDTH   = 32
);
   // stage control and redirect from execute
   logic                fq_i_ce;
   logic                fq_i_redirect;
   logic [PC_WIDTH-1:0] fq_i_redirect_pc;

   // instruction memory read port
   logic                fq_o_mem_req;
   logic [PC_WIDTH-1:0] fq_o_mem_addr;
   logic                fq_i_mem_ack;
   logic [IWIDTH-1:0]   fq_i_mem_data;

   // head of queue toward decode
   logic                fq_o_valid;
   logic [PC_WIDTH-1:0] fq_o_pc;
   logic [IWIDTH-1:0]   fq_o_instr;
   logic                fq_i_ready;

   modport master (
      input  fq_i_ce, fq_i_redirect, fq_i_redirect_pc,
      input  fq_i_mem_ack, fq_i_mem_data, fq_i_ready,
      output fq_o_mem_req, fq_o_mem_addr,
      output fq_o_valid, fq_o_pc, fq_o_instr
   );

   modport slave (
      output fq_i_ce, fq_i_redirect, fq_i_redirect_pc,
      output fq_i_mem_ack, fq_i_mem_data, fq_i_ready,
      input  fq_o_mem_req, fq_o_mem_addr,
      input  fq_o_valid, fq_o_pc, fq_o_instr
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential PC generation, single-outstanding
// memory request, first-word-fall-through {pc, instr} queue, and flush on redirect.
module fetch_queue #(
   parameter int unsigned          PC_WIDTH   = 32,
   parameter int unsigned          IWIDTH     = 32,
   parameter int unsigned          FIFO_DEPTH = 4,
   parameter int unsigned          PTR_WIDTH  = 2,
   parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic          fq_clk,
   input  logic          fq_rst,
   fetch_queue_if.master fq_bus
);

   localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

   // request / PC state
   logic                 r_req;
   logic [PC_WIDTH-1:0]  r_addr;
   logic [PC_WIDTH-1:0]  r_fetch_pc;
   logic                 r_discard;

   // queue state
   logic [CNT_WIDTH-1:0] r_count;
   logic [PTR_WIDTH-1:0] r_wr_ptr;
   logic [PTR_WIDTH-1:0] r_rd_ptr;
   logic [PC_WIDTH-1:0]  r_pc_mem    [FIFO_DEPTH];
   logic [IWIDTH-1:0]    r_instr_mem [FIFO_DEPTH];

   // next-state values
   logic                 w_req_nxt;
   logic [PC_WIDTH-1:0]  w_addr_nxt;
   logic [PC_WIDTH-1:0]  w_fetch_pc_nxt;
   logic                 w_discard_nxt;
   logic [CNT_WIDTH-1:0] w_count_nxt;
   logic [PTR_WIDTH-1:0] w_wr_ptr_nxt;
   logic [PTR_WIDTH-1:0] w_rd_ptr_nxt;

   // per-edge events
   logic                 w_ack;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_valid;
   logic                 w_outstanding;
   logic                 w_issue;
   logic [PC_WIDTH-1:0]  w_redirect_pc;

   // Word-align the restart address; low two bits are don't-care.
   assign w_redirect_pc = fq_bus.fq_i_redirect_pc & ~PC_WIDTH'(3);

   // Handshake events for this edge.
   assign w_valid       = (r_count != '0);
   assign w_ack         = r_req && fq_bus.fq_i_mem_ack;
   assign w_push        = w_ack && !r_discard && !fq_bus.fq_i_redirect;
   assign w_pop         = w_valid && fq_bus.fq_i_ready && fq_bus.fq_i_ce;
   assign w_outstanding = r_req && !fq_bus.fq_i_mem_ack;

   // Post-edge occupancy; a redirect empties the queue outright.
   always_comb begin
      w_count_nxt  = r_count;
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      if (fq_bus.fq_i_redirect) begin
         w_count_nxt  = '0;
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
      end else begin
         w_count_nxt = r_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);
         if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_WIDTH'(1);
         end
         if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_WIDTH'(1);
         end
      end
   end

   // Issue only with a free slot counted after this edge's push/pop, so a
   // returning response always has room.
   assign w_issue = fq_bus.fq_i_ce && !fq_bus.fq_i_redirect && !w_outstanding &&
                    (w_count_nxt < CNT_WIDTH'(FIFO_DEPTH));

   // Request, fetch PC and discard next-state.
   always_comb begin
      w_req_nxt      = r_req;
      w_addr_nxt     = r_addr;
      w_fetch_pc_nxt = r_fetch_pc;
      w_discard_nxt  = r_discard;
      if (fq_bus.fq_i_redirect) begin
         w_fetch_pc_nxt = w_redirect_pc;
         if (w_outstanding) begin
            // keep the in-flight request stable and drop its response later
            w_discard_nxt = 1'b1;
         end else begin
            w_req_nxt     = 1'b0;
            w_discard_nxt = 1'b0;
         end
      end else begin
         if (w_ack) begin
            w_req_nxt     = 1'b0;
            w_discard_nxt = 1'b0;
         end
         if (w_issue) begin
            w_req_nxt      = 1'b1;
            w_addr_nxt     = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + PC_WIDTH'(4);
         end
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge fq_clk) begin
      if (fq_rst) begin
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
         r_fetch_pc <= RESET_PC;
         r_discard  <= 1'b0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_req      <= w_req_nxt;
         r_addr     <= w_addr_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_discard  <= w_discard_nxt;
         r_count    <= w_count_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
      end
   end

   // Queue storage; contents are only observable through the valid gate.
   always_ff @(posedge fq_clk) begin
      if (!fq_rst && w_push) begin
         r_pc_mem[r_wr_ptr]    <= r_addr;
         r_instr_mem[r_wr_ptr] <= fq_bus.fq_i_mem_data;
      end
   end

   // Outputs: memory port from registers, head read through the read pointer.
   assign fq_bus.fq_o_mem_req  = r_req;
   assign fq_bus.fq_o_mem_addr = r_addr;
   assign fq_bus.fq_o_valid    = w_valid;
   assign fq_bus.fq_o_pc       = w_valid ? r_pc_mem[r_rd_ptr]    : '0;
   assign fq_bus.fq_o_instr    = w_valid ? r_instr_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: sequential fetch, queue full, redirect
// cases, stall, reset mid-transaction and PC wrap.
module tb_fetch_queue;

   localparam logic [31:0] XK = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst;
   logic ack_auto;
   logic ack_man;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   fetch_queue_if #(.PC_WIDTH(32), .IWIDTH(32)) bus ();

   // memory: data is the address scrambled; ack either mirrors req or is manual
   assign bus.fq_i_mem_ack  = ack_auto ? bus.fq_o_mem_req : ack_man;
   assign bus.fq_i_mem_data = bus.fq_o_mem_addr ^ XK;

   fetch_queue #(
      .PC_WIDTH(32), .IWIDTH(32), .FIFO_DEPTH(4), .PTR_WIDTH(2), .RESET_PC(32'h0)
   ) dut (
      .fq_clk(clk),
      .fq_rst(rst),
      .fq_bus(bus.master)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      ack_auto = 1'b0;
      ack_man  = 1'b0;
      bus.fq_i_ce = 1'b1;
      bus.fq_i_redirect = 1'b0;
      bus.fq_i_redirect_pc = 32'h0;
      bus.fq_i_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ack_auto = 1'b0;
      ack_man  = 1'b0;
      bus.fq_i_ce = 1'b1;
      bus.fq_i_redirect = 1'b0;
      bus.fq_i_redirect_pc = 32'h0;
      bus.fq_i_ready = 1'b0;
      tick();
      tick();
      n_checks++; if (bus.fq_o_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.fq_o_mem_req); end
      n_checks++; if (bus.fq_o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.fq_o_mem_addr); end
      n_checks++; if (bus.fq_o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.fq_o_valid); end
      n_checks++; if (bus.fq_o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", bus.fq_o_pc); end
      n_checks++; if (bus.fq_o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", bus.fq_o_instr); end
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      apply_reset();
      ack_auto = 1'b1;
      bus.fq_i_ready = 1'b1;
      tick();
      n_checks++; if (bus.fq_o_mem_req !== 1'b1 || bus.fq_o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL seq_first_req: got req=%b addr=%h expected req=1 addr=0", bus.fq_o_mem_req, bus.fq_o_mem_addr); end
      n_checks++; if (bus.fq_o_valid !== 1'b0) begin n_fail++; $display("FAIL seq_first_valid: got %b expected 0", bus.fq_o_valid); end
      for (int k = 1; k <= 6; k++) begin
         tick();
         n_checks++; if (bus.fq_o_mem_req !== 1'b1 || bus.fq_o_mem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", k, bus.fq_o_mem_req, bus.fq_o_mem_addr, 32'(4 * k)); end
         n_checks++; if (bus.fq_o_valid !== 1'b1 || bus.fq_o_pc !== 32'(4 * (k - 1))) begin n_fail++; $display("FAIL seq_head_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", k, bus.fq_o_valid, bus.fq_o_pc, 32'(4 * (k - 1))); end
         n_checks++; if (bus.fq_o_instr !== (32'(4 * (k - 1)) ^ XK)) begin n_fail++; $display("FAIL seq_head_instr[%0d]: got %h expected %h", k, bus.fq_o_instr, 32'(4 * (k - 1)) ^ XK); end
      end
   endtask

   task automatic test_full();
      apply_reset();
      ack_auto = 1'b1;
      bus.fq_i_ready = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      n_checks++; if (bus.fq_o_mem_req !== 1'b0) begin n_fail++; $display("FAIL full_req_low: got %b expected 0", bus.fq_o_mem_req); end
      n_checks++; if (bus.fq_o_mem_addr !== 32'hC) begin n_fail++; $display("FAIL full_last_addr: got %h expected c", bus.fq_o_mem_addr); end
      n_checks++; if (bus.fq_o_valid !== 1'b1 || bus.fq_o_pc !== 32'h0) begin n_fail++; $display("FAIL full_head: got valid=%b pc=%h expected valid=1 pc=0", bus.fq_o_valid, bus.fq_o_pc); end
      tick();
      n_checks++; if (bus.fq_o_mem_req !== 1'b0) begin n_fail++; $display("FAIL full_req_hold: got %b expected 0", bus.fq_o_mem_req); end
      bus.fq_i_ready = 1'b1;
      tick();
      bus.fq_i_ready = 1'b0;
      n_checks++; if (bus.fq_o_mem_req !== 1'b1 || bus.fq_o_mem_addr !== 32'h10) begin n_fail++; $display("FAIL full_refill_req: got req=%b addr=%h expected req=1 addr=10", bus.fq_o_mem_req, bus.fq_o_mem_addr); end
      n_checks++; if (bus.fq_o_pc !== 32'h4) begin n_fail++; $display("FAIL full_pop_head: got %h expected 4", bus.fq_o_pc); end
      tick();
      n_checks++; if (bus.fq_o_mem_req !== 1'b0) begin n_fail++; $display("FAIL full_again_req: got %b expected 0", bus.fq_o_mem_req); end
      bus.fq_i_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++; if (bus.fq_o_pc !== 32'(8 + 4 * k)) begin n_fail++; $display("FAIL full_drain[%0d]: got %h expected %h", k, bus.fq_o_pc, 32'(8 + 4 * k)); end
      end
   endtask

   task automatic test_redirect_outstanding();
      apply_reset();
      bus.fq_i_ready = 1'b1;
      tick();
      ack_man = 1'b1;
      tick();
      tick();
      ack_man = 1'b0;
      bus.fq_i_ready = 1'b0;
      tick();
      n_checks++; if (bus.fq_o_valid !== 1'b1 || bus.fq_o_pc !== 32'h4 || bus.fq_o_mem_addr !== 32'h8) begin n_fail++; $display("FAIL redir_setup: got valid=%b pc=%h addr=%h expected 1/4/8", bus.fq_o_valid, bus.fq_o_pc, bus.fq_o_mem_addr); end
      bus.fq_i_redirect = 1'b1;
      bus.fq_i_redirect_pc = 32'h103;
      tick();
      bus.fq_i_redirect = 1'b0;
      n_checks++; if (bus.fq_o_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got valid=%b expected 0", bus.fq_o_valid); end
      n_checks++; if (bus.fq_o_mem_req !== 1'b1 || bus.fq_o_mem_addr !== 32'h8) begin n_fail++; $display("FAIL redir_hold_req: got req=%b addr=%h expected req=1 addr=8", bus.fq_o_mem_req, bus.fq_o_mem_addr); end
      tick();
      n_checks++; if (bus.fq_o_mem_req !== 1'b1 || bus.fq_o_mem_addr !== 32'h8) begin n_fail++; $display("FAIL redir_hold_req2: got req=%b addr=%h expected req=1 addr=8", bus.fq_o_mem_req, bus.fq_o_mem_addr); end
      ack_man = 1'b1;
      tick();
      n_checks++; if (bus.fq_o_valid !== 1'b0) begin n_fail++; $display("FAIL redir_discard: got valid=%b expected 0", bus.fq_o_valid); end
      n_checks++; if (bus.fq_o_mem_req !== 1'b1 || bus.fq_o_mem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_new_req: got req=%b addr=%h expected req=1 addr=100", bus.fq_o_mem_req, bus.fq_o_mem_addr); end
      tick();
      ack_man = 1'b0;
      n_checks++; if (bus.fq_o_valid !== 1'b1 || bus.fq_o_pc !== 32'h100 || bus.fq_o_instr !== (32'h100 ^ XK)) begin n_fail++; $display("FAIL redir_new_head: got valid=%b pc=%h instr=%h expected 1/100/%h", bus.fq_o_valid, bus.fq_o_pc, bus.fq_o_instr, 32'h100 ^ XK); end
      n_checks++; if (bus.fq_o_mem_addr !== 32'h104) begin n_fail++; $display("FAIL redir_next_addr: got %h expected 104", bus.fq_o_mem_addr); end
   endtask

   task automatic test_redirect_on_ack();
      apply_reset();
      tick();
      ack_man = 1'b1;
      tick();
      n_checks++; if (bus.fq_o_mem_addr !== 32'h4 || bus.fq_o_valid !== 1'b1) begin n_fail++; $display("FAIL rack_setup: got addr=%h valid=%b expected 4/1", bus.fq_o_mem_addr, bus.fq_o_valid); end
      bus.fq_i_redirect = 1'b1;
      bus.fq_i_redirect_pc = 32'h200;
      tick();
      bus.fq_i_redirect = 1'b0;
      ack_man = 1'b0;
      n_checks++; if (bus.fq_o_mem_req !== 1'b0 || bus.fq_o_valid !== 1'b0) begin n_fail++; $display("FAIL rack_drop: got req=%b valid=%b expected 0/0", bus.fq_o_mem_req, bus.fq_o_valid); end
      tick();
      n_checks++; if (bus.fq_o_mem_req !== 1'b1 || bus.fq_o_mem_addr !== 32'h200) begin n_fail++; $display("FAIL rack_new_req: got req=%b addr=%h expected req=1 addr=200", bus.fq_o_mem_req, bus.fq_o_mem_addr); end
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      n_checks++; if (bus.fq_o_valid !== 1'b1 || bus.fq_o_pc !== 32'h200) begin n_fail++; $display("FAIL rack_no_discard: got valid=%b pc=%h expected 1/200", bus.fq_o_valid, bus.fq_o_pc); end
   endtask

   task automatic test_stall();
      apply_reset();
      bus.fq_i_ready = 1'b1;
      tick();
      ack_man = 1'b1;
      tick();
      bus.fq_i_ce = 1'b0;
      ack_man = 1'b0;
      tick();
      n_checks++; if (bus.fq_o_valid !== 1'b1 || bus.fq_o_pc !== 32'h0) begin n_fail++; $display("FAIL stall_no_pop: got valid=%b pc=%h expected 1/0", bus.fq_o_valid, bus.fq_o_pc); end
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      n_checks++; if (bus.fq_o_mem_req !== 1'b0) begin n_fail++; $display("FAIL stall_no_issue: got req=%b expected 0", bus.fq_o_mem_req); end
      n_checks++; if (bus.fq_o_pc !== 32'h0) begin n_fail++; $display("FAIL stall_head: got %h expected 0", bus.fq_o_pc); end
      tick();
      n_checks++; if (bus.fq_o_mem_req !== 1'b0 || bus.fq_o_pc !== 32'h0) begin n_fail++; $display("FAIL stall_hold: got req=%b pc=%h expected 0/0", bus.fq_o_mem_req, bus.fq_o_pc); end
      bus.fq_i_ce = 1'b1;
      tick();
      n_checks++; if (bus.fq_o_mem_req !== 1'b1 || bus.fq_o_mem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_resume_req: got req=%b addr=%h expected req=1 addr=8", bus.fq_o_mem_req, bus.fq_o_mem_addr); end
      n_checks++; if (bus.fq_o_valid !== 1'b1 || bus.fq_o_pc !== 32'h4) begin n_fail++; $display("FAIL stall_resume_head: got valid=%b pc=%h expected 1/4", bus.fq_o_valid, bus.fq_o_pc); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      tick();
      ack_man = 1'b1;
      tick();
      tick();
      tick();
      ack_man = 1'b0;
      n_checks++; if (bus.fq_o_mem_addr !== 32'hC || bus.fq_o_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: got addr=%h valid=%b expected c/1", bus.fq_o_mem_addr, bus.fq_o_valid); end
      rst = 1'b1;
      tick();
      n_checks++; if (bus.fq_o_valid !== 1'b0 || bus.fq_o_mem_req !== 1'b0 || bus.fq_o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_clear: got valid=%b req=%b addr=%h expected 0/0/0", bus.fq_o_valid, bus.fq_o_mem_req, bus.fq_o_mem_addr); end
      rst = 1'b0;
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      n_checks++; if (bus.fq_o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_ack: got valid=%b expected 0", bus.fq_o_valid); end
      n_checks++; if (bus.fq_o_mem_req !== 1'b1 || bus.fq_o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_first_req: got req=%b addr=%h expected req=1 addr=0", bus.fq_o_mem_req, bus.fq_o_mem_addr); end
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      n_checks++; if (bus.fq_o_valid !== 1'b1 || bus.fq_o_pc !== 32'h0) begin n_fail++; $display("FAIL rstmid_first_head: got valid=%b pc=%h expected 1/0", bus.fq_o_valid, bus.fq_o_pc); end
   endtask

   task automatic test_wrap();
      apply_reset();
      ack_auto = 1'b1;
      bus.fq_i_ready = 1'b1;
      bus.fq_i_redirect = 1'b1;
      bus.fq_i_redirect_pc = 32'hFFFF_FFFF;
      tick();
      bus.fq_i_redirect = 1'b0;
      n_checks++; if (bus.fq_o_mem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_no_issue: got req=%b expected 0", bus.fq_o_mem_req); end
      tick();
      n_checks++; if (bus.fq_o_mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top_addr: got %h expected fffffffc", bus.fq_o_mem_addr); end
      tick();
      n_checks++; if (bus.fq_o_mem_addr !== 32'h0 || bus.fq_o_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_rollover: got addr=%h pc=%h expected 0/fffffffc", bus.fq_o_mem_addr, bus.fq_o_pc); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_full();
      test_redirect_outstanding();
      test_redirect_on_ack();
      test_stall();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
